// File: rtl/mem_scheduler_pkg.sv
// Shared widths, frame size and encodings for the ZBT memory scheduler.
// Read-owner tags travel with each read so returning data reaches the right client.
package mem_scheduler_pkg;

    localparam int MEM_W           = 36;
    localparam int ADDR_W          = 19;
    localparam int FRAME_WORDS_DEF = 153600;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_PROC = 2'd2
    } tag_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VGA  = 2'd1,
        GNT_NTSC = 2'd2,
        GNT_PROC = 2'd3
    } grant_e;

    // Fixed priority: display never starves, camera beats processing.
    function automatic grant_e arbitrate(input logic vga_req,
                                         input logic ntsc_req,
                                         input logic proc_req);
        if (vga_req) begin
            return GNT_VGA;
        end
        if (ntsc_req) begin
            return GNT_NTSC;
        end
        if (proc_req) begin
            return GNT_PROC;
        end
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/mem_scheduler_wrap_counter.sv
// Modulo-N up counter with synchronous clear; wrap pulses in the cycle the
// counter steps from MODULUS-1 back to 0.
module wrap_counter #(
    parameter int WIDTH   = 18,
    parameter int MODULUS = 153600
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        wrap    = inc && !clear && (count_q == LAST);
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = wrap ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_scheduler.sv
// Single-port ZBT scheduler: display reads, camera writes and processing reads,
// with double-buffered frames swapped at vertical blank.
module mem_scheduler
    import mem_scheduler_pkg::*;
#(
    parameter int LOG_MEM     = MEM_W,
    parameter int LOG_ADDR    = ADDR_W,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                frame_flag,
    input  logic                vga_flag,
    output logic [LOG_MEM-1:0]  vga_pixel,
    output logic                done_vga,
    input  logic                ntsc_flag,
    input  logic [LOG_MEM-1:0]  ntsc_pixel,
    output logic                done_ntsc,
    input  logic                proc_flag,
    input  logic [LOG_ADDR-1:0] proc_addr,
    output logic [LOG_MEM-1:0]  proc_pixel,
    output logic                done_proc,
    output logic [LOG_ADDR-1:0] mem_addr,
    output logic                mem_we,
    output logic [LOG_MEM-1:0]  mem_din,
    input  logic [LOG_MEM-1:0]  mem_dout,
    output logic                display_buf
);

    // The top address bit selects the frame buffer; the rest index within it.
    localparam int BUF_W = LOG_ADDR - 1;

    grant_e              grant;
    tag_e                tag_in;
    logic [BUF_W-1:0]    vga_addr;
    logic [BUF_W-1:0]    ntsc_addr;
    logic                vga_wrap_unused;
    logic                ntsc_wrap;
    logic                swap;

    logic [LOG_ADDR-1:0] mem_addr_d,    mem_addr_q;
    logic                display_buf_d, display_buf_q;
    logic                frame_done_d,  frame_done_q;
    tag_e                tag1_d,        tag1_q;
    tag_e                tag2_d,        tag2_q;

    // The display restarts its frame on frame_flag, so its request that cycle is dropped.
    always_comb begin
        grant = GNT_NONE;
        if (!reset) begin
            grant = arbitrate(vga_flag && !frame_flag, ntsc_flag, proc_flag);
        end
    end

    wrap_counter #(
        .WIDTH   (BUF_W),
        .MODULUS (FRAME_WORDS)
    ) u_vga_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (grant == GNT_VGA),
        .clear (frame_flag),
        .count (vga_addr),
        .wrap  (vga_wrap_unused)
    );

    wrap_counter #(
        .WIDTH   (BUF_W),
        .MODULUS (FRAME_WORDS)
    ) u_ntsc_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (grant == GNT_NTSC),
        .clear (1'b0),
        .count (ntsc_addr),
        .wrap  (ntsc_wrap)
    );

    always_comb begin
        mem_addr_d = reset ? '0 : mem_addr_q;
        mem_we     = 1'b0;
        mem_din    = '0;
        done_ntsc  = 1'b0;
        tag_in     = TAG_NONE;
        unique case (grant)
            GNT_VGA: begin
                mem_addr_d = {display_buf_q, vga_addr};
                tag_in     = TAG_VGA;
            end
            GNT_NTSC: begin
                mem_addr_d = {~display_buf_q, ntsc_addr};
                mem_we     = 1'b1;
                mem_din    = ntsc_pixel;
                done_ntsc  = 1'b1;
            end
            GNT_PROC: begin
                mem_addr_d = proc_addr;
                tag_in     = TAG_PROC;
            end
            default: begin
            end
        endcase
    end

    // A wrap landing on frame_flag swaps immediately instead of arming the sticky flag.
    always_comb begin
        swap          = frame_flag && (frame_done_q || ntsc_wrap);
        display_buf_d = display_buf_q ^ swap;
        frame_done_d  = frame_flag ? 1'b0 : (frame_done_q || ntsc_wrap);
        tag1_d        = tag_in;
        tag2_d        = tag1_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr_q    <= '0;
            display_buf_q <= 1'b0;
            frame_done_q  <= 1'b0;
            tag1_q        <= TAG_NONE;
            tag2_q        <= TAG_NONE;
        end else begin
            mem_addr_q    <= mem_addr_d;
            display_buf_q <= display_buf_d;
            frame_done_q  <= frame_done_d;
            tag1_q        <= tag1_d;
            tag2_q        <= tag2_d;
        end
    end

    always_comb begin
        done_vga    = !reset && (tag2_q == TAG_VGA);
        done_proc   = !reset && (tag2_q == TAG_PROC);
        vga_pixel   = done_vga  ? mem_dout : '0;
        proc_pixel  = done_proc ? mem_dout : '0;
        mem_addr    = mem_addr_d;
        display_buf = display_buf_q;
    end

endmodule
